// File: rtl/mskaes_arb_pkg.sv
// Shared definitions for the masked-AES request arbiter: FSM encoding,
// block width and default watchdog limit.
package mskaes_arb_pkg;

    localparam int unsigned BlkW       = 128;
    localparam int unsigned DefTimeout = 128;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StGrant = 2'd1,
        StBusy  = 2'd2,
        StHold  = 2'd3
    } arb_state_e;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mskaes_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr_i,
// wrapping modulo NREQ.
module mskaes_rr_pick
    import mskaes_arb_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req_valid_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [IDW-1:0]  grant_o,
    output logic            any_valid_o
);

    always_comb begin
        int unsigned idx;
        idx         = 0;
        grant_o     = '0;
        any_valid_o = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(ptr_i) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!any_valid_o && req_valid_i[idx[IDW-1:0]]) begin
                any_valid_o = 1'b1;
                grant_o     = idx[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/mskaes_req_arbiter.sv
// Round-robin scheduler sharing one iterative masked AES-128 core between NREQ
// requesters, with held response, backpressure and a latency watchdog.
module mskaes_req_arbiter
    import mskaes_arb_pkg::*;
#(
    parameter int unsigned d       = 2,
    parameter int unsigned NREQ    = 2,
    parameter int unsigned IDW     = id_width(NREQ),
    parameter int unsigned TIMEOUT = DefTimeout
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*BlkW*d-1:0]   req_pt,
    input  logic [NREQ*BlkW*d-1:0]   req_key,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic [BlkW*d-1:0]        rsp_ct,
    output logic                     core_valid_in,
    input  logic                     core_ready,
    input  logic                     core_cipher_valid,
    output logic [BlkW*d-1:0]        core_pt,
    output logic [BlkW*d-1:0]        core_key,
    input  logic [BlkW*d-1:0]        core_ct,
    output logic                     busy,
    output logic                     err
);

    localparam int unsigned SW   = BlkW * d;
    localparam int unsigned CntW = $clog2(TIMEOUT) + 1;

    arb_state_e        state_q;
    logic [IDW-1:0]    grant_q;
    logic [IDW-1:0]    ptr_q;
    logic [IDW-1:0]    rsp_id_q;
    logic [SW-1:0]     rsp_ct_q;
    logic              rsp_valid_q;
    logic              err_q;
    logic [CntW-1:0]   cnt_q;

    logic [IDW-1:0]    pick_idx;
    logic              pick_any;
    logic              gnt_live;
    logic [IDW-1:0]    ptr_d;
    logic [NREQ-1:0]   sel;

    mskaes_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .req_valid_i (req_valid),
        .ptr_i       (ptr_q),
        .grant_o     (pick_idx),
        .any_valid_o (pick_any)
    );

    // The offer to the core is withdrawn if the granted requester drops valid,
    // so a protocol-violating requester can never cause a phantom accept.
    assign gnt_live = (state_q == StGrant) && req_valid[grant_q];
    assign ptr_d    = (grant_q == IDW'(NREQ - 1)) ? '0 : grant_q + IDW'(1);

    always_comb begin
        sel = '0;
        if (state_q == StGrant) begin
            sel[grant_q] = 1'b1;
        end
    end

    always_comb begin
        req_ready = '0;
        if (gnt_live) begin
            req_ready[grant_q] = core_ready;
        end
    end

    // Per-share AND/OR selection; share s of the core only ever sees share s
    // of the granted requester, and all-zero shares outside GRANT.
    always_comb begin
        core_pt  = '0;
        core_key = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            for (int unsigned s = 0; s < d; s++) begin
                core_pt[s*BlkW +: BlkW]  = core_pt[s*BlkW +: BlkW]
                                         | (req_pt[(i*d+s)*BlkW +: BlkW] & {BlkW{sel[i]}});
                core_key[s*BlkW +: BlkW] = core_key[s*BlkW +: BlkW]
                                         | (req_key[(i*d+s)*BlkW +: BlkW] & {BlkW{sel[i]}});
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            ptr_q       <= '0;
            rsp_id_q    <= '0;
            rsp_ct_q    <= '0;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            if (core_cipher_valid && (state_q != StBusy)) begin
                err_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (pick_any) begin
                        grant_q <= pick_idx;
                        state_q <= StGrant;
                    end
                end
                StGrant: begin
                    if (!req_valid[grant_q]) begin
                        state_q <= StIdle;
                    end else if (core_ready) begin
                        rsp_id_q <= grant_q;
                        ptr_q    <= ptr_d;
                        cnt_q    <= '0;
                        state_q  <= StBusy;
                    end
                end
                StBusy: begin
                    if (core_cipher_valid) begin
                        rsp_ct_q    <= core_ct;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StHold;
                    end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StHold: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_ct_q    <= '0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign core_valid_in = gnt_live;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_id        = rsp_id_q;
    assign rsp_ct        = rsp_ct_q;
    assign busy          = (state_q != StIdle);
    assign err           = err_q;

    a_ready_onehot: assert property (@(posedge clk) disable iff (!nrst) $onehot0(req_ready));
    a_hold_no_offer: assert property (@(posedge clk) disable iff (!nrst)
                                      rsp_valid |-> !core_valid_in);

endmodule

// File: tb/tb_mskaes_req_arbiter.sv
// Directed bench for mskaes_req_arbiter with a behavioural core model that
// answers FIPS-197 C.1 and a simple XOR cipher for other inputs.
module tb_mskaes_req_arbiter;

    localparam int unsigned TO = 128;

    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT1      = 128'h11111111111111111111111111111111;
    localparam logic [127:0] KEY1     = 128'h22222222222222222222222222222222;
    localparam logic [127:0] CT1      = 128'h33333333333333333333333333333333;

    logic          clk = 1'b0;
    logic          nrst;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [511:0]  req_pt;
    logic [511:0]  req_key;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [0:0]    rsp_id;
    logic [255:0]  rsp_ct;
    logic          core_valid_in;
    logic          core_ready;
    logic          core_cipher_valid;
    logic [255:0]  core_pt;
    logic [255:0]  core_key;
    logic [255:0]  core_ct;
    logic          busy;
    logic          err;

    int n_cmp = 0;
    int n_bad = 0;
    int hyg_bad = 0;

    mskaes_req_arbiter #(
        .d       (2),
        .NREQ    (2),
        .TIMEOUT (TO)
    ) dut (
        .clk               (clk),
        .nrst              (nrst),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_pt            (req_pt),
        .req_key           (req_key),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_id            (rsp_id),
        .rsp_ct            (rsp_ct),
        .core_valid_in     (core_valid_in),
        .core_ready        (core_ready),
        .core_cipher_valid (core_cipher_valid),
        .core_pt           (core_pt),
        .core_key          (core_key),
        .core_ct           (core_ct),
        .busy              (busy),
        .err               (err)
    );

    always #5 clk = ~clk;

    // Core model
    logic         mc_busy;
    logic         mc_cv;
    logic         mc_silent;
    logic         tb_stray;
    int           mc_cnt;
    int           mc_lat;
    logic [127:0] mc_pt;
    logic [127:0] mc_key;
    int           n_acc = 0;
    logic [0:0]   acc_id [0:31];

    assign core_cipher_valid = mc_cv | tb_stray;

    function automatic logic [127:0] ref_ct(input logic [127:0] pt, input logic [127:0] key);
        if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
        return pt ^ key;
    endfunction

    always @(posedge clk or negedge nrst) begin : model_core
        logic [127:0] r;
        if (!nrst) begin
            mc_busy    <= 1'b0;
            mc_cv      <= 1'b0;
            core_ready <= 1'b1;
            mc_cnt     <= 0;
            core_ct    <= '0;
        end else begin
            mc_cv <= 1'b0;
            if (!mc_busy && core_valid_in && core_ready) begin
                mc_busy    <= 1'b1;
                core_ready <= 1'b0;
                mc_cnt     <= 0;
                mc_pt      <= core_pt[127:0] ^ core_pt[255:128];
                mc_key     <= core_key[127:0] ^ core_key[255:128];
                acc_id[n_acc[4:0]] <= req_ready[1];
                n_acc      <= n_acc + 1;
            end else if (mc_busy && !mc_silent) begin
                if (mc_cnt >= mc_lat - 1) begin
                    r          = {$urandom, $urandom, $urandom, $urandom};
                    mc_cv      <= 1'b1;
                    core_ct    <= {ref_ct(mc_pt, mc_key) ^ r, r};
                    mc_busy    <= 1'b0;
                    core_ready <= 1'b1;
                end else begin
                    mc_cnt <= mc_cnt + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Waits for rsp_valid; records the negedge index of the cipher pulse and
    // of the response so their spacing can be checked.
    task automatic wait_rsp(output bit ok, output int cv_cyc, output int rv_cyc);
        ok = 1'b0;
        cv_cyc = -1;
        rv_cyc = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!core_valid_in && (core_pt !== '0 || core_key !== '0)) hyg_bad++;
            if (core_cipher_valid && cv_cyc < 0) cv_cyc = i;
            if (rsp_valid) begin
                rv_cyc = i;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic [1:0]   rv;
        int           lat;
        int           hold;
        logic [0:0]   exp_id;
        logic [127:0] exp_ct;
    } vec_t;

    vec_t tbl [6];

    initial begin
        bit           ok;
        int           cv;
        int           rv;
        int           n0;
        int           err_k;
        int           bad;
        logic [255:0] snap_ct;
        logic [0:0]   snap_id;
        logic [127:0] r0;
        logic [127:0] r1;
        logic [127:0] r2;
        logic [127:0] r3;
        logic [0:0]   fair_exp [4];

        nrst      = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        tb_stray  = 1'b0;
        mc_silent = 1'b0;
        mc_lat    = 4;
        r0 = {$urandom, $urandom, $urandom, $urandom};
        r1 = {$urandom, $urandom, $urandom, $urandom};
        r2 = {$urandom, $urandom, $urandom, $urandom};
        r3 = {$urandom, $urandom, $urandom, $urandom};
        req_pt  = {PT1 ^ r2, r2, FIPS_PT ^ r0, r0};
        req_key = {KEY1 ^ r3, r3, FIPS_KEY ^ r1, r1};

        tbl[0] = '{2'b01, 3, 0, 1'b0, FIPS_CT};
        tbl[1] = '{2'b01, 1, 2, 1'b0, FIPS_CT};
        tbl[2] = '{2'b11, 5, 0, 1'b1, CT1};
        tbl[3] = '{2'b11, 2, 1, 1'b0, FIPS_CT};
        tbl[4] = '{2'b10, 7, 3, 1'b1, CT1};
        tbl[5] = '{2'b10, 1, 0, 1'b1, CT1};
        fair_exp = '{1'b0, 1'b1, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst_req_ready", 256'(req_ready), '0);
        chk("rst_ctrl", {core_valid_in, rsp_valid, busy, err}, '0);
        chk("rst_rsp_id", 256'(rsp_id), '0);
        chk("rst_rsp_ct", rsp_ct, '0);
        chk("rst_core_data", {core_pt | core_key}, '0);
        nrst = 1'b1;
        @(negedge clk);

        // Table-driven single transactions
        for (int t = 0; t < 6; t++) begin
            mc_lat    = tbl[t].lat;
            req_valid = tbl[t].rv;
            wait_rsp(ok, cv, rv);
            chk($sformatf("row%0d_rsp_seen", t), 256'(ok), 256'(1));
            chk($sformatf("row%0d_rsp_lat", t), 256'(rv - cv), 256'(1));
            chk($sformatf("row%0d_rsp_id", t), 256'(rsp_id), 256'(tbl[t].exp_id));
            chk($sformatf("row%0d_ct", t), 256'(rsp_ct[127:0] ^ rsp_ct[255:128]),
                256'(tbl[t].exp_ct));
            req_valid = 2'b00;
            repeat (tbl[t].hold) @(negedge clk);
            chk($sformatf("row%0d_held", t), 256'(rsp_valid), 256'(1));
            ack();
            chk($sformatf("row%0d_drain", t), {rsp_ct[254:0], rsp_valid}, '0);
        end

        // Fairness: both requesters valid continuously
        mc_lat    = 2;
        n0        = n_acc;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_rsp(ok, cv, rv);
            chk($sformatf("fair%0d_id", k), 256'(rsp_id), 256'(fair_exp[k]));
            ack();
            chk($sformatf("fair%0d_gap", k), 256'(core_valid_in), '0);
            if (k == 3) req_valid = 2'b00;
        end
        chk("fair_accepts", 256'(n_acc - n0), 256'(4));
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("fair%0d_grant", k), 256'(acc_id[n0 + k]), 256'(fair_exp[k]));
        end

        // Backpressure
        mc_lat    = 3;
        req_valid = 2'b11;
        wait_rsp(ok, cv, rv);
        chk("bp_first_id", 256'(rsp_id), '0);
        snap_ct = rsp_ct;
        snap_id = rsp_id;
        n0      = n_acc;
        bad     = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rsp_ct !== snap_ct || rsp_id !== snap_id || req_ready !== 2'b00 ||
                rsp_valid !== 1'b1 || core_valid_in !== 1'b0) bad++;
        end
        chk("bp_stable", 256'(bad), '0);
        chk("bp_no_grant", 256'(n_acc - n0), '0);
        ack();
        wait_rsp(ok, cv, rv);
        chk("bp_next_id", 256'(rsp_id), 256'(1));
        chk("bp_next_ct", 256'(rsp_ct[127:0] ^ rsp_ct[255:128]), 256'(CT1));
        req_valid = 2'b00;
        ack();

        // Watchdog: core never answers
        mc_silent = 1'b1;
        req_valid = 2'b01;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (core_valid_in && core_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("to_accept_seen", 256'(ok), 256'(1));
        @(negedge clk);
        req_valid = 2'b00;
        err_k = -1;
        for (int k = 0; k < TO + 10; k++) begin
            if (k > 0) @(negedge clk);
            if (err) begin
                err_k = k;
                break;
            end
        end
        chk("to_cycles", 256'(err_k), 256'(TO));
        chk("to_idle", {busy, rsp_valid}, '0);

        // Reset mid-BUSY clears sticky err and aborts the request
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_clears_err", 256'(err), '0);
        nrst      = 1'b1;
        mc_silent = 1'b0;
        mc_lat    = 50;
        req_valid = 2'b10;
        repeat (30) @(negedge clk);
        chk("mid_busy_pre", {busy, rsp_id}, 256'(2'b11));
        nrst = 1'b0;
        #1;
        chk("mid_rst_ctrl", {req_ready, core_valid_in, rsp_valid, busy, err}, '0);
        chk("mid_rst_id_ct", {rsp_ct[254:0], rsp_id}, '0);
        chk("mid_rst_core", {core_pt | core_key}, '0);
        req_valid = 2'b00;
        @(negedge clk);
        nrst = 1'b1;
        bad  = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (rsp_valid || busy) bad++;
            if (!core_valid_in && (core_pt !== '0 || core_key !== '0)) hyg_bad++;
        end
        chk("post_rst_quiet", 256'(bad), '0);

        // Stray cipher pulse in IDLE
        chk("stray_pre_err", 256'(err), '0);
        tb_stray = 1'b1;
        @(negedge clk);
        tb_stray = 1'b0;
        @(negedge clk);
        chk("stray_err", 256'(err), 256'(1));
        chk("stray_no_rsp", {rsp_valid, busy}, '0);
        chk("stray_idle_core", {core_pt | core_key}, '0);

        chk("hygiene", 256'(hyg_bad), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1);
    end

endmodule
